// File: rtl/piso_if.sv
// piso_if: load handshake and serial-side signals of piso_serializer
interface piso_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             lsb_first;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  modport master (
    output in_valid, in_data, lsb_first,
    input  in_ready, ser_out, ser_valid, busy, done
  );
  modport slave (
    input  in_valid, in_data, lsb_first,
    output in_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: handshaked PISO shifter with bit period and bit-order select.
// PISO_SKID_BUF_EN adds a one-word holding register for zero-gap back-to-back frames.
module piso_serializer #(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic IDLE_VAL     = 1'b0
) (
  input logic   clk,
  input logic   rst,
  piso_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, src_data;
  logic             lsb, src_lsb, done_q;
  logic [BW-1:0]    bcnt;
  logic [TW-1:0]    tcnt;
  logic             acc, bit_end, last_tick, load;
  assign acc       = bus.in_valid && bus.in_ready;
  assign bit_end   = tcnt == TW'(CLKS_PER_BIT - 1);
  assign last_tick = state == SHIFT && bit_end && bcnt == BW'(WIDTH - 1);
`ifdef PISO_SKID_BUF_EN
  logic             full, hold_lsb;
  logic [WIDTH-1:0] hold_data;
  // a held word, if any, takes priority over the input at frame end
  assign load     = (state == IDLE && acc) || (last_tick && (full || acc));
  assign src_data = full ? hold_data : bus.in_data;
  assign src_lsb  = full ? hold_lsb : bus.lsb_first;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full      <= 1'b0;
      hold_data <= '0;
      hold_lsb  <= 1'b0;
    end else if (acc && state == SHIFT && !last_tick) begin
      full      <= 1'b1;
      hold_data <= bus.in_data;
      hold_lsb  <= bus.lsb_first;
    end else if (last_tick) begin
      full <= 1'b0;
    end
`else
  assign load     = acc;
  assign src_data = bus.in_data;
  assign src_lsb  = bus.lsb_first;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx      = load ? SHIFT : last_tick ? IDLE : state;
`ifdef PISO_SKID_BUF_EN
    bus.in_ready  = !rst && !full;
`else
    bus.in_ready  = !rst && state == IDLE;
`endif
    bus.ser_valid = state == SHIFT;
    bus.busy      = state == SHIFT;
    bus.ser_out   = state == SHIFT ? (lsb ? sreg[0] : sreg[WIDTH-1]) : IDLE_VAL;
    bus.done      = done_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sreg   <= '0;
      lsb    <= 1'b0;
      bcnt   <= '0;
      tcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_tick;
      if (load) begin
        sreg <= src_data;
        lsb  <= src_lsb;
        bcnt <= '0;
        tcnt <= '0;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          tcnt <= '0;
          bcnt <= last_tick ? '0 : bcnt + BW'(1);
          sreg <= lsb ? sreg >> 1 : sreg << 1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
endmodule
